// File: rtl/fdtd_bank_ram_if.sv
// Request/response bundle for the multi-bank FDTD field buffer.
// The master side drives the read/write/clear requests and the slave side answers.
interface fdtd_bank_ram_if #(
    parameter int FDTD_DATA_WIDTH   = 32,
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int BANK_SEL_WIDTH    = 1
);
    logic                         en;
    logic                         wren;
    logic [BANK_SEL_WIDTH-1:0]    wr_bank;
    logic [BUFFER_ADDR_WIDTH-1:0] addr_a;
    logic [FDTD_DATA_WIDTH-1:0]   din;
    logic                         rden;
    logic [BANK_SEL_WIDTH-1:0]    rd_bank;
    logic [BUFFER_ADDR_WIDTH-1:0] addr_b;
    logic [FDTD_DATA_WIDTH-1:0]   dout;
    logic                         dout_valid;
    logic                         clr_start;
    logic                         clr_busy;

    modport master (
        output en, wren, wr_bank, addr_a, din, rden, rd_bank, addr_b, clr_start,
        input  dout, dout_valid, clr_busy
    );

    modport slave (
        input  en, wren, wr_bank, addr_a, din, rden, rd_bank, addr_b, clr_start,
        output dout, dout_valid, clr_busy
    );
endinterface

// File: rtl/fdtd_bank_ram.sv
// Multi-bank FDTD field buffer: one write port, one registered read port with
// write-first forwarding, and a sequential engine that zeroes all banks.
module fdtd_bank_ram #(
    parameter int FDTD_DATA_WIDTH   = 32,
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int BUFFER_RAM_DEPTH  = 64,
    parameter int NUM_BANKS         = 2,
    parameter int BANK_SEL_WIDTH    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input logic            CLK,
    input logic            RST,
    fdtd_bank_ram_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [BANK_SEL_WIDTH:0]    BANK_LIMIT  = (BANK_SEL_WIDTH+1)'(NUM_BANKS);
    localparam logic [BUFFER_ADDR_WIDTH:0] DEPTH_LIMIT = (BUFFER_ADDR_WIDTH+1)'(BUFFER_RAM_DEPTH);
    localparam logic [BUFFER_ADDR_WIDTH:0] CLR_LAST    = (BUFFER_ADDR_WIDTH+1)'(BUFFER_RAM_DEPTH-1);

    logic [FDTD_DATA_WIDTH-1:0] mem [NUM_BANKS][BUFFER_RAM_DEPTH];

    state_t                       state;
    state_t                       next_state;
    logic [BUFFER_ADDR_WIDTH:0]   clr_cnt;
    logic                         busy;
    logic                         clear_we;
    logic                         wr_in_range;
    logic                         rd_in_range;
    logic                         wr_hit;
    logic                         rd_hit;
    logic                         forward;
    logic [FDTD_DATA_WIDTH-1:0]   rd_word;
    logic [FDTD_DATA_WIDTH-1:0]   dout_q;
    logic                         valid_q;

    assign wr_in_range = ({1'b0, bus.wr_bank} < BANK_LIMIT) &&
                         ({1'b0, bus.addr_a} < DEPTH_LIMIT);
    assign rd_in_range = ({1'b0, bus.rd_bank} < BANK_LIMIT) &&
                         ({1'b0, bus.addr_b} < DEPTH_LIMIT);

    assign wr_hit  = bus.en && bus.wren && !busy && wr_in_range;
    assign rd_hit  = bus.en && bus.rden && !busy;
    assign forward = wr_hit && rd_in_range &&
                     (bus.wr_bank == bus.rd_bank) && (bus.addr_a == bus.addr_b);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Reset gates the clear write so an aborted clear leaves the current word untouched.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        clear_we   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_start) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                busy     = 1'b1;
                clear_we = !RST;
                if (clr_cnt == CLR_LAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end else begin
            clr_cnt <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (clear_we) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem[b][clr_cnt[BUFFER_ADDR_WIDTH-1:0]] <= '0;
            end
        end else if (wr_hit) begin
            mem[bus.wr_bank][bus.addr_a] <= bus.din;
        end
    end

    always_comb begin
        rd_word = '0;
        if (forward) begin
            rd_word = bus.din;
        end else if (rd_in_range) begin
            rd_word = mem[bus.rd_bank][bus.addr_b];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (rd_hit) begin
            dout_q  <= rd_word;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.clr_busy   = busy;
endmodule
